alu_muldiv_sequencer: RTL and testbench

Iterative unsigned multiply/divide sequencer that shares the EX-stage ALU between the normal pipeline and a 32-cycle shift-add multiplier / restoring divider. In idle it passes EX-stage operands straight to the ALU. During a multiply/divide it takes the ALU over, drives add/sub micro-operations, stalls the pipeline, and writes the HI/LO result registers.

---
 rtl/alu_muldiv_sequencer.sv | 153 +++++++++++++++
 tb/tb_alu_muldiv_sequencer.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_muldiv_sequencer.sv
// Iterative unsigned MULTU/DIVU sequencer sharing the EX-stage ALU.
// Idle: the EX operands pass straight to the ALU. Busy: the block owns the ALU for
// N_ITER cycles (shift-add multiply / restoring divide) and stalls the pipeline.
module alu_muldiv_sequencer #(
    parameter int unsigned N_ITER = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] ex_in1,
    input  logic [31:0] ex_in2,
    input  logic [2:0]  ex_sel,
    input  logic [4:0]  ex_shamt,
    input  logic        md_start,
    input  logic        md_op,
    input  logic [31:0] md_a,
    input  logic [31:0] md_b,
    output logic [31:0] alu_in1,
    output logic [31:0] alu_in2,
    output logic [2:0]  alu_sel,
    output logic [4:0]  alu_shamt,
    input  logic [31:0] alu_out,
    output logic        stall,
    output logic        md_busy,
    output logic        md_done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int unsigned CntW = $clog2(N_ITER);
    localparam logic [CntW-1:0] LastCnt = CntW'(N_ITER - 1);
    localparam logic [2:0] SelAdd = 3'b000;
    localparam logic [2:0] SelSub = 3'b010;

    typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    // w_hi: acc (MUL) / rem (DIV); w_lo: mpr / quo; w_op: mcand / dvs
    logic [31:0]     w_hi_q, w_hi_d;
    logic [31:0]     w_lo_q, w_lo_d;
    logic [31:0]     w_op_q, w_op_d;
    logic [31:0]     hi_q, hi_d;
    logic [31:0]     lo_q, lo_d;

    logic            carry;
    logic            ge;
    logic [31:0]     r_sh;

    // State, counter, working and result registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            w_hi_q  <= '0;
            w_lo_q  <= '0;
            w_op_q  <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            w_hi_q  <= w_hi_d;
            w_lo_q  <= w_lo_d;
            w_op_q  <= w_op_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    // Next-state, iteration datapath and ALU ownership mux.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        w_hi_d    = w_hi_q;
        w_lo_d    = w_lo_q;
        w_op_d    = w_op_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        alu_in1   = ex_in1;
        alu_in2   = ex_in2;
        alu_sel   = ex_sel;
        alu_shamt = ex_shamt;
        carry     = 1'b0;
        ge        = 1'b0;
        r_sh      = '0;

        unique case (state_q)
            StIdle, StDone: begin
                state_d = StIdle;
                if (md_start) begin
                    cnt_d  = '0;
                    w_hi_d = '0;
                    w_lo_d = md_op ? md_a : md_b;
                    w_op_d = md_op ? md_b : md_a;
                    if (!md_op) begin
                        state_d = StMul;
                    end else if (md_b != '0) begin
                        state_d = StDiv;
                    end else begin
                        // Divide by zero: finish at once with a fixed result
                        state_d = StDone;
                        hi_d    = md_a;
                        lo_d    = '1;
                    end
                end
            end
            StMul: begin
                alu_in1   = w_hi_q;
                alu_in2   = w_op_q;
                alu_sel   = SelAdd;
                alu_shamt = '0;
                carry     = (alu_out < w_hi_q);
                if (w_lo_q[0]) begin
                    {w_hi_d, w_lo_d} = {carry, alu_out, w_lo_q[31:1]};
                end else begin
                    {w_hi_d, w_lo_d} = {1'b0, w_hi_q, w_lo_q[31:1]};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LastCnt) begin
                    state_d = StDone;
                    hi_d    = w_hi_d;
                    lo_d    = w_lo_d;
                end
            end
            StDiv: begin
                r_sh      = {w_hi_q[30:0], w_lo_q[31]};
                alu_in1   = r_sh;
                alu_in2   = w_op_q;
                alu_sel   = SelSub;
                alu_shamt = '0;
                // Bit shifted out of rem makes the partial remainder exceed 32 bits
                ge        = w_hi_q[31] | (r_sh >= w_op_q);
                w_hi_d    = ge ? alu_out : r_sh;
                w_lo_d    = {w_lo_q[30:0], ge};
                cnt_d     = cnt_q + 1'b1;
                if (cnt_q == LastCnt) begin
                    state_d = StDone;
                    hi_d    = w_hi_d;
                    lo_d    = w_lo_d;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Status decodes come from registered state only.
    assign stall   = (state_q == StMul) || (state_q == StDiv);
    assign md_busy = stall;
    assign md_done = (state_q == StDone);
    assign hi      = hi_q;
    assign lo      = lo_q;

endmodule

// File: tb/tb_alu_muldiv_sequencer.sv
// Scoreboard bench for alu_muldiv_sequencer with a behavioural ALU model.
module tb_alu_muldiv_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] ex_in1, ex_in2;
    logic [2:0]  ex_sel;
    logic [4:0]  ex_shamt;
    logic        md_start, md_op;
    logic [31:0] md_a, md_b;
    logic [31:0] alu_in1, alu_in2, alu_out;
    logic [2:0]  alu_sel;
    logic [4:0]  alu_shamt;
    logic        stall, md_busy, md_done;
    logic [31:0] hi, lo;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t        sb_q[$];
    int          n_total = 0;
    int          n_bad = 0;
    logic [31:0] prev_hi = '0;
    logic [31:0] prev_lo = '0;

    always #5 clk = ~clk;

    alu_muldiv_sequencer #(.N_ITER(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .ex_in1   (ex_in1),
        .ex_in2   (ex_in2),
        .ex_sel   (ex_sel),
        .ex_shamt (ex_shamt),
        .md_start (md_start),
        .md_op    (md_op),
        .md_a     (md_a),
        .md_b     (md_b),
        .alu_in1  (alu_in1),
        .alu_in2  (alu_in2),
        .alu_sel  (alu_sel),
        .alu_shamt(alu_shamt),
        .alu_out  (alu_out),
        .stall    (stall),
        .md_busy  (md_busy),
        .md_done  (md_done),
        .hi       (hi),
        .lo       (lo)
    );

    // External ALU: add/sub are what the sequencer relies on.
    always_comb begin
        case (alu_sel)
            3'b000:  alu_out = alu_in1 + alu_in2;
            3'b010:  alu_out = alu_in1 - alu_in2;
            default: alu_out = alu_in1 ^ alu_in2;
        endcase
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Scoreboard monitor: every completion pulse must match the oldest pending op.
    always @(negedge clk) begin
        if (!reset && md_done) begin
            if (sb_q.size() == 0) begin
                check_eq("unexpected_done", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check_eq("hi", {32'd0, hi}, {32'd0, e.hi});
                check_eq("lo", {32'd0, lo}, {32'd0, e.lo});
            end
        end
    end

    // Drive one op (called at a negedge). busy_cyc: cycle of an extra start to be
    // ignored; rst_cyc: cycle during which reset is asserted (0 = none).
    task automatic run_op(input logic op, input logic [31:0] a, input logic [31:0] b,
                          input int busy_cyc, input int rst_cyc);
        exp_t        e;
        logic [63:0] p;
        int          exp_lat, exp_stalls, done_cyc, stalls;
        if (!op) begin
            p       = {32'd0, a} * {32'd0, b};
            e.hi    = p[63:32];
            e.lo    = p[31:0];
            exp_lat = 33;
        end else if (b == 0) begin
            e.hi    = a;
            e.lo    = 32'hFFFF_FFFF;
            exp_lat = 1;
        end else begin
            e.hi    = a % b;
            e.lo    = a / b;
            exp_lat = 33;
        end
        exp_stalls = (exp_lat == 33) ? 32 : 0;
        sb_q.push_back(e);
        md_start = 1'b1;
        md_op    = op;
        md_a     = a;
        md_b     = b;
        @(posedge clk);
        #1;
        done_cyc = 0;
        stalls   = 0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            md_start = (cyc == busy_cyc);
            if (cyc == busy_cyc) begin
                md_op = ~op;
                md_a  = a ^ 32'h5A5A_0F0F;
                md_b  = b + 32'd3;
            end
            if (cyc == rst_cyc) begin
                reset = 1'b1;
                @(posedge clk);
                #1;
                reset = 1'b0;
                check_eq("rst_stall", {63'd0, stall}, 64'd0);
                check_eq("rst_busy", {63'd0, md_busy}, 64'd0);
                check_eq("rst_done", {63'd0, md_done}, 64'd0);
                check_eq("rst_hilo", {hi, lo}, 64'd0);
                sb_q.delete();
                prev_hi = '0;
                prev_lo = '0;
                repeat (3) @(negedge clk);
                return;
            end
            @(negedge clk);
            if (stall) stalls++;
            if (md_done) begin
                done_cyc = cyc;
                break;
            end
            if (cyc == 5) begin
                check_eq("hold_hilo", {hi, lo}, {prev_hi, prev_lo});
                check_eq("busy_mid", {63'd0, md_busy}, 64'd1);
                check_eq("alu_sel_mid", {61'd0, alu_sel}, op ? 64'd2 : 64'd0);
            end
            @(posedge clk);
            #1;
        end
        check_eq("latency", 64'(done_cyc), 64'(exp_lat));
        check_eq("stall_cycles", 64'(stalls), 64'(exp_stalls));
        if (done_cyc == 0) sb_q.delete();
        prev_hi = e.hi;
        prev_lo = e.lo;
    endtask

    initial begin
        reset    = 1'b1;
        md_start = 1'b0;
        md_op    = 1'b0;
        md_a     = '0;
        md_b     = '0;
        ex_in1   = '0;
        ex_in2   = '0;
        ex_sel   = '0;
        ex_shamt = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check_eq("reset_hilo", {hi, lo}, 64'd0);
        check_eq("reset_stall", {63'd0, stall}, 64'd0);
        check_eq("reset_busy", {63'd0, md_busy}, 64'd0);
        check_eq("reset_done", {63'd0, md_done}, 64'd0);

        ex_sel   = 3'b010;
        ex_in1   = 32'd9;
        ex_in2   = 32'd4;
        ex_shamt = 5'd3;
        #1;
        check_eq("pt_sel", {61'd0, alu_sel}, 64'd2);
        check_eq("pt_in1", {32'd0, alu_in1}, 64'd9);
        check_eq("pt_in2", {32'd0, alu_in2}, 64'd4);
        check_eq("pt_shamt", {59'd0, alu_shamt}, 64'd3);
        check_eq("pt_stall", {63'd0, stall}, 64'd0);
        @(negedge clk);

        run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
        repeat (2) @(negedge clk);
        run_op(1'b0, 32'd7, 32'd6, 0, 0);
        repeat (2) @(negedge clk);
        run_op(1'b1, 32'd100, 32'd7, 0, 0);
        repeat (2) @(negedge clk);
        run_op(1'b1, 32'h8000_0000, 32'd3, 0, 0);
        repeat (2) @(negedge clk);
        run_op(1'b1, 32'd123, 32'd0, 0, 0);
        repeat (2) @(negedge clk);
        run_op(1'b0, 32'h1234_5678, 32'h9ABC_DEF0, 10, 0);
        repeat (2) @(negedge clk);
        // Back-to-back: the second start is issued during DONE of the first
        run_op(1'b1, 32'd1000, 32'd33, 0, 0);
        run_op(1'b0, 32'd40000, 32'd50000, 0, 0);
        repeat (2) @(negedge clk);
        run_op(1'b0, 32'hDEAD_BEEF, 32'h0000_1234, 0, 15);
        run_op(1'b0, 32'd3, 32'd5, 0, 0);
        repeat (3) @(negedge clk);
        check_eq("sb_empty", 64'(sb_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
